// File: rtl/oaum_pkg.sv
// Shared constants and helpers for the approximate mantissa multiplier pipeline.
package oaum_pkg;

    localparam int unsigned DEFAULT_W = 15;
    localparam int unsigned PROD_W = 2 * DEFAULT_W + 2;

    function automatic int unsigned lvl_width(input int unsigned max_level);
        return (max_level < 1) ? 1 : $clog2(max_level + 1);
    endfunction

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w + 2;
    endfunction

    // Compensation for the dropped low partial-product rows at level l.
    function automatic logic [63:0] comp_const(input int unsigned w, input int unsigned l);
        return 64'(1) << (2 * w - l - 2);
    endfunction

endpackage

// File: rtl/oaum_mantissa_pipe_csa_row.sv
// 3:2 carry-save row; the carry vector comes out pre-shifted, top carry dropped (mod 2^WIDTH).
module csa_row #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cy
);

    always_comb begin
        sum = a ^ b ^ c;
        cy  = {(a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
               (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};
    end

endmodule

// File: rtl/oaum_mantissa_pipe.sv
// Three-stage approximate mantissa multiplier: operand regs, CSA reduction, CPA + normalize.
module oaum_mantissa_pipe
    import oaum_pkg::*;
#(
    parameter int unsigned MANTISSA_WIDTH = 15,
    parameter int unsigned MAX_LEVEL      = 3,
    parameter int unsigned TAG_WIDTH      = 4,
    parameter int unsigned LVL_W          = lvl_width(MAX_LEVEL)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANTISSA_WIDTH-1:0] mant_x,
    input  logic [MANTISSA_WIDTH-1:0] mant_y,
    input  logic [LVL_W-1:0]          level,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANTISSA_WIDTH-1:0] mant_out,
    output logic                      carry,
    output logic [TAG_WIDTH-1:0]      tag_out
);

    localparam int unsigned W    = MANTISSA_WIDTH;
    localparam int unsigned PW   = prod_width(W);
    localparam int unsigned NOPS = W + 3;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [LVL_W-1:0] lc_in;
    assign lc_in = (32'(level) > MAX_LEVEL) ? LVL_W'(MAX_LEVEL) : level;

    // Stage 1: operand registers
    logic                 v1;
    logic [W-1:0]         x1, y1;
    logic [LVL_W-1:0]     lc1;
    logic [TAG_WIDTH-1:0] tag1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            x1   <= '0;
            y1   <= '0;
            lc1  <= '0;
            tag1 <= '0;
        end else if (adv) begin
            v1   <= in_valid;
            x1   <= mant_x;
            y1   <= mant_y;
            lc1  <= lc_in;
            tag1 <= tag_in;
        end
    end

    // Operand 0 merges the hidden-bit product with the compensation constant (no overlap).
    logic [PW-1:0] ops [NOPS];

    always_comb begin
        ops[0] = (PW'(1) << (2 * W)) | ((lc1 != '0) ? PW'(comp_const(W, 32'(lc1))) : '0);
        ops[1] = PW'(x1) << W;
        ops[2] = PW'(y1) << W;
        for (int j = 0; j < int'(W); j++) begin
            if (((lc1 == '0) || (j + int'(lc1) >= int'(W))) && y1[j]) begin
                ops[j+3] = PW'(x1) << j;
            end else begin
                ops[j+3] = '0;
            end
        end
    end

    for (genvar k = 0; k < NOPS - 2; k++) begin : g_csa
        logic [PW-1:0] in_s, in_c, s, cy;
        if (k == 0) begin : g_first
            assign in_s = ops[0];
            assign in_c = ops[1];
        end else begin : g_next
            assign in_s = g_csa[k-1].s;
            assign in_c = g_csa[k-1].cy;
        end
        csa_row #(.WIDTH(PW)) u_csa (
            .a  (in_s),
            .b  (in_c),
            .c  (ops[k+2]),
            .sum(s),
            .cy (cy)
        );
    end

    logic [PW-1:0] red_s, red_c;
    assign red_s = g_csa[NOPS-3].s;
    assign red_c = g_csa[NOPS-3].cy;

    // Stage 2: carry-save vectors
    logic                 v2;
    logic [PW-1:0]        s2, c2;
    logic [TAG_WIDTH-1:0] tag2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2   <= '0;
            c2   <= '0;
            tag2 <= '0;
        end else if (adv) begin
            v2   <= v1;
            s2   <= red_s;
            c2   <= red_c;
            tag2 <= tag1;
        end
    end

    logic [PW-1:0] prod;
    logic [W-1:0]  norm_mant;
    logic          norm_carry;
    logic          unused_lo;

    always_comb begin
        prod       = s2 + c2;
        norm_carry = prod[2*W+1];
        norm_mant  = norm_carry ? prod[2*W:W+1] : prod[2*W-1:W];
    end

    // Bits below the result LSB are truncated.
    assign unused_lo = ^prod[W-1:0];

    // Stage 3: output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mant_out  <= '0;
            carry     <= 1'b0;
            tag_out   <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                mant_out <= norm_mant;
                carry    <= norm_carry;
                tag_out  <= tag2;
            end
        end
    end

endmodule

// File: tb/tb_oaum_mantissa_pipe.sv
// Scoreboard bench for oaum_mantissa_pipe at W=15, MAX_LEVEL=3.
module tb_oaum_mantissa_pipe;
    import oaum_pkg::*;

    localparam int W  = 15;
    localparam int TW = 4;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, carry;
    logic [W-1:0]  mant_x, mant_y, mant_out;
    logic [1:0]    level;
    logic [TW-1:0] tag_in, tag_out;

    oaum_mantissa_pipe #(
        .MANTISSA_WIDTH(W),
        .MAX_LEVEL     (3),
        .TAG_WIDTH     (TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mant_x   (mant_x),
        .mant_y   (mant_y),
        .level    (level),
        .tag_in   (tag_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mant_out (mant_out),
        .carry    (carry),
        .tag_out  (tag_out)
    );

    typedef struct {
        logic [W-1:0]  mant;
        logic          cy;
        logic [TW-1:0] tag;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product straight from the arithmetic definition; returns {carry, mant}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input int lvl);
        logic [PROD_W-1:0] p;
        int lc;
        lc = (lvl > 3) ? 3 : lvl;
        if (lc == 0) begin
            p = ((PROD_W'(1) << W) + PROD_W'(x)) * ((PROD_W'(1) << W) + PROD_W'(y));
        end else begin
            p = (PROD_W'(1) << (2 * W)) + ((PROD_W'(x) + PROD_W'(y)) << W);
            for (int i = 1; i <= lc; i++) begin
                if (y[W-i]) p = p + (PROD_W'(x) << (W - i));
            end
            p = p + (PROD_W'(1) << (2 * W - lc - 2));
        end
        return p[2*W+1] ? {1'b1, p[2*W:W+1]} : {1'b0, p[2*W-1:W]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got tag 0x%0h expected none", tag_out);
            end else begin
                mon_e = sbq.pop_front();
                chk("mant_out", 32'(mant_out), 32'(mon_e.mant));
                chk("carry", 32'(carry), 32'(mon_e.cy));
                chk("tag_out", 32'(tag_out), 32'(mon_e.tag));
                if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'd3);
            end
        end
    end

    // Called at posedge+1; returns at the posedge+1 after acceptance.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] lvl,
                        input logic [TW-1:0] tg, input logic [W:0] e, input bit lat);
        int waited = 0;
        in_valid = 1'b1;
        mant_x   = x;
        mant_y   = y;
        level    = lvl;
        tag_in   = tg;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 (tag 0x%0h)", tg);
        end else begin
            sbq.push_back('{mant: e[W-1:0], cy: e[W], tag: tg, acc: cyc, lat: lat});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] x, y;
        rst_n = 1'b1;
        in_valid = 1'b0;
        mant_x = '0;
        mant_y = '0;
        level = '0;
        tag_in = '0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mant_out", 32'(mant_out), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_tag_out", 32'(tag_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hand-computed directed vectors
        send(15'h4000, 15'h4000, 2'd0, 4'h1, {1'b1, 15'h1000}, 1'b1);
        send(15'h4000, 15'h4000, 2'd1, 4'h2, {1'b1, 15'h1800}, 1'b1);
        send(15'h4000, 15'h4000, 2'd3, 4'h3, {1'b1, 15'h1200}, 1'b1);
        send(15'h7FFF, 15'h7FFF, 2'd0, 4'h4, {1'b1, 15'h7FFE}, 1'b1);
        send(15'h0000, 15'h0000, 2'd2, 4'h5, {1'b0, 15'h0800}, 1'b1);
        drain();

        // Back-to-back stream, mixed levels
        for (int i = 0; i < 8; i++) begin
            x = 15'(i * 32'h0913 + 32'h0101);
            y = 15'(32'h7FFF - i * 32'h0A31);
            send(x, y, 2'(i % 4), 4'(i), model(x, y, i % 4), 1'b1);
        end
        drain();

        // Fill the pipe with the output stalled
        out_ready = 1'b0;
        send(15'h1234, 15'h5678, 2'd1, 4'hA, model(15'h1234, 15'h5678, 1), 1'b0);
        send(15'h6ABC, 15'h0F0F, 2'd3, 4'hB, model(15'h6ABC, 15'h0F0F, 3), 1'b0);
        send(15'h2222, 15'h7001, 2'd0, 4'hC, model(15'h2222, 15'h7001, 0), 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_mant_out", 32'(mant_out), 32'(sbq[0].mant));
            chk("stall_carry", 32'(carry), 32'(sbq[0].cy));
            chk("stall_tag_out", 32'(tag_out), 32'hA);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset with two transactions in flight
        send(15'h3333, 15'h4444, 2'd2, 4'hD, model(15'h3333, 15'h4444, 2), 1'b1);
        send(15'h5555, 15'h6666, 2'd1, 4'hE, model(15'h5555, 15'h6666, 1), 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_mant_out", 32'(mant_out), 32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        chk("midrst_tag_out", 32'(tag_out), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_hold_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(15'h4000, 15'h4000, 2'd0, 4'h6, {1'b1, 15'h1000}, 1'b1);
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
